board_display_scanner: RTL
==========================

# board_display_scanner

Display-side reader for the Connect Four game core. It drives the core's board read address (`row_read`/`col_read`) and consumes the 2-bit cell data it returns. It serialises a cursor row plus the full 8x8 board into a 74HC595-style shift-register chain (`sclk`/`sdo`/`latch`) that feeds the LED matrix. One frame is shifted and latched per `enable` request, or back-to-back frames while `enable` stays high.

## Interface
- `ROWS`, 8: board rows scanned.
- `COLS`, 8: board columns scanned.
- `ROW_BITS`, 3: width of `row_read`.
- `COL_BITS`, 3: width of `col_read`.
- `CLK_DIV`, 2: `sclk` half-period (D) in `clk` cycles; legal range 1..15.
- `RD_LAT`, 1: board read latency (L) in `clk` cycles, address to valid `cell_data`; legal range 1..3.

Ports:
- `clk` in 1: single system clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: frame request; sampled in IDLE.
- `cell_data` in 2: board cell value from the game core (00 empty, 01 P1, 10 P2).
- `current_col` in 3: cursor column from the game core.
- `current_player` in 2: player to move.
- `game_over` in 1: game core win flag.
- `row_read` out ROW_BITS: board read row.
- `col_read` out COL_BITS: board read column.
- `sclk` out 1: shift clock; the shift register samples on its rising edge.
- `sdo` out 1: serial data.
- `latch` out 1: storage-register strobe, active high.
- `frame_done` out 1: one-cycle pulse at the end of each frame.

## Operation
- States: IDLE, CURSOR, FETCH, SHIFT, LATCH.
- Leaving IDLE:
  - IDLE with `enable`=1 goes to CURSOR on the next cycle.
  - `current_col`, `current_player` and `game_over` are snapshotted on that same edge.
  - Inputs changing mid-frame do not affect the frame in progress.
- CURSOR shifts 16 bits.
  - For c = 0..7: 2 bits, MSB first.
  - Value is the snapshot `current_player` if c equals the snapshot `current_col`, else 00.
- FETCH then SHIFT, once per cell:
  - Cells are visited row 0..7 (outer) and col 0..7 (inner).
  - FETCH drives the cell address and holds it for L cycles.
  - `cell_data` is captured on the L-th cycle.
  - SHIFT emits the 2 captured bits MSB first while the address stays held.
  - After cell (7,7) the FSM goes to LATCH.
- Bit cell (every shifted bit):
  - `sdo` updates at the start of the bit with `sclk`=0.
  - `sclk` stays 0 for D cycles, then 1 for D cycles.
- LATCH:
  - `sclk`=0 and `latch`=1 for D cycles.
  - Then IDLE, with `frame_done`=1 for that first IDLE cycle.
  - If `enable`=1 in that cycle, the next frame starts.
- Bit stream per frame:
  - 144 bits: cursor bits 0..15, then cell (r,c) at bits 16+2*(8r+c) and 17+2*(8r+c).
- `enable` dropped mid-frame: the current frame completes; no new frame starts.
- Reset mid-frame: the frame is aborted immediately and no latch pulse is issued.
- Scan counters: row/col counters with wrap at COLS-1 to 0 and row increment; the FSM exits to LATCH on (ROWS-1, COLS-1).

## Timing
- Reset values: `sclk`=0, `sdo`=0, `latch`=0, `row_read`=0, `col_read`=0, `frame_done`=0, state IDLE, internal frame toggle=0.
- Frame period with `enable` held high (edge of `frame_done` to edge of next `frame_done`): 32D + 64(L+4D) + D + 1 cycles. This is 643 for D=2, L=1.
- First `sclk` rise occurs D+1 cycles after the IDLE cycle that sampled `enable`=1.
- `row_read`/`col_read` change only on entry to FETCH; they are stable through FETCH and SHIFT for that cell.
- `latch` never overlaps `sclk`=1.

## Configuration
- `BLINK_ON_WIN_EN` defined:
  - A frame toggle flips at every `frame_done`.
  - When the snapshot `game_over`=1 and the toggle=1, all 144 bits are shifted as 0. Fetch cycles still occur, so timing is unchanged.
  - Result: the display blinks at half the frame rate after a win.
- Not defined: no toggle register; `game_over` is ignored and every frame shows the board.

## Test plan
- Reset and idle: assert `rst` mid-operation with `enable`=0 after release. All outputs must be 0 and stay 0 for 2000 cycles.
- Empty board, `current_col`=3, `current_player`=01, one-cycle `enable` pulse:
  - 144 bits are captured on `sclk` rises; bits 6,7 = 0,1 and all others are 0.
  - Exactly one `latch` pulse, 2 cycles wide.
  - `frame_done` fires once.
- Board model returning (r+c)%3 with L=1:
  - Address sequence is 0..63 in row-major order.
  - Bits 16+2k..17+2k match the model for every cell.
  - Changing `current_col` mid-frame does not alter the frame in progress; the next frame shows the new value.
- `enable` held high: `frame_done` pulses every 643 cycles. Dropping `enable` mid-frame completes that frame, then the block stays IDLE.
- Reset asserted during SHIFT of cell (4,5):
  - Outputs drop to 0 asynchronously and no `latch` pulse occurs.
  - The next `enable` produces a full, correct 144-bit frame.
- `BLINK_ON_WIN_EN` defined, `game_over`=1, full board: frames alternate between board content and all-zero. With the macro undefined, every frame shows the board.

Source files
------------

// File: rtl/board_display_scanner.sv
// board_display_scanner: reads the game core's 8x8 board and serialises a
// cursor row plus every cell into a 595-style shift-register chain.
// Optional feature macro: BLINK_ON_WIN_EN (blanks every other frame after a win).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for enable; snapshots cursor/player/game_over on exit
// CURSOR | shifting 16 cursor bits (2 per column, MSB first)
// FETCH  | board address held for RD_LAT cycles, cell_data captured on last
// SHIFT  | shifting the 2 captured cell bits, address still held
// LATCH  | latch high, sclk low, for CLK_DIV cycles
module board_display_scanner #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int ROW_BITS = 3,
    parameter int COL_BITS = 3,
    parameter int CLK_DIV  = 2,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          cell_data,
    input  logic [2:0]          current_col,
    input  logic [1:0]          current_player,
    input  logic                game_over,
    output logic [ROW_BITS-1:0] row_read,
    output logic [COL_BITS-1:0] col_read,
    output logic                sclk,
    output logic                sdo,
    output logic                latch,
    output logic                frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CURSOR,
        S_FETCH,
        S_SHIFT,
        S_LATCH
    } state_t;

    localparam logic [3:0]          HALF_M1 = 4'(CLK_DIV - 1);
    localparam logic [3:0]          LAT_M1  = 4'(RD_LAT - 1);
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(COLS - 1);

    state_t              state_q, state_d;
    logic [3:0]          tmr_q, tmr_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic                sclk_q, sclk_d;
    logic                sdo_q, sdo_d;
    logic                latch_q, latch_d;
    logic                frame_done_q, frame_done_d;
    logic [2:0]          snap_col_q, snap_col_d;
    logic [1:0]          snap_player_q, snap_player_d;
    logic                blank_q, blank_d;
    logic                lsb_q, lsb_d;
    logic                tick;
    logic                toggle_q;

    // Cursor bit idx: column idx[3:1], MSB first within the column.
    function automatic logic cursor_bit(input logic [3:0] idx, input logic [2:0] col,
                                        input logic [1:0] pl, input logic blank);
        logic [1:0] v;
        v = (idx[3:1] == col) ? pl : 2'b00;
        return blank ? 1'b0 : (idx[0] ? v[0] : v[1]);
    endfunction

    assign tick = (tmr_q == 4'd0);

`ifdef BLINK_ON_WIN_EN
    logic toggle_d;

    // Frame toggle flips on each frame completion.
    always_comb begin
        toggle_d = toggle_q;
        if (state_q == S_LATCH && tick) toggle_d = ~toggle_q;
    end

    // Toggle register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) toggle_q <= 1'b0;
        else     toggle_q <= toggle_d;
    end
`else
    assign toggle_q = 1'b0;
`endif

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        bit_cnt_d     = bit_cnt_q;
        row_d         = row_q;
        col_d         = col_q;
        sclk_d        = sclk_q;
        sdo_d         = sdo_q;
        latch_d       = latch_q;
        frame_done_d  = 1'b0;
        snap_col_d    = snap_col_q;
        snap_player_d = snap_player_q;
        blank_d       = blank_q;
        lsb_d         = lsb_q;
        case (state_q)
            S_IDLE: begin
                sclk_d  = 1'b0;
                latch_d = 1'b0;
                if (enable) begin
                    state_d       = S_CURSOR;
                    snap_col_d    = current_col;
                    snap_player_d = current_player;
                    blank_d       = game_over & toggle_q;
                    bit_cnt_d     = 4'd0;
                    tmr_d         = HALF_M1;
                    sdo_d         = cursor_bit(4'd0, current_col, current_player,
                                               game_over & toggle_q);
                end
            end
            S_CURSOR: begin
                if (!tick) begin
                    tmr_d = tmr_q - 4'd1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    tmr_d  = HALF_M1;
                end else begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == 4'd15) begin
                        state_d = S_FETCH;
                        row_d   = '0;
                        col_d   = '0;
                        tmr_d   = LAT_M1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tmr_d     = HALF_M1;
                        sdo_d     = cursor_bit(bit_cnt_q + 4'd1, snap_col_q,
                                               snap_player_q, blank_q);
                    end
                end
            end
            S_FETCH: begin
                if (!tick) begin
                    tmr_d = tmr_q - 4'd1;
                end else begin
                    state_d   = S_SHIFT;
                    lsb_d     = cell_data[0];
                    sdo_d     = cell_data[1] & ~blank_q;
                    bit_cnt_d = 4'd0;
                    tmr_d     = HALF_M1;
                    sclk_d    = 1'b0;
                end
            end
            S_SHIFT: begin
                if (!tick) begin
                    tmr_d = tmr_q - 4'd1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    tmr_d  = HALF_M1;
                end else begin
                    sclk_d = 1'b0;
                    if (!bit_cnt_q[0]) begin
                        bit_cnt_d = 4'd1;
                        sdo_d     = lsb_q & ~blank_q;
                        tmr_d     = HALF_M1;
                    end else if (row_q == ROW_MAX && col_q == COL_MAX) begin
                        state_d = S_LATCH;
                        latch_d = 1'b1;
                        sdo_d   = 1'b0;
                        tmr_d   = HALF_M1;
                    end else begin
                        state_d = S_FETCH;
                        tmr_d   = LAT_M1;
                        if (col_q == COL_MAX) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            S_LATCH: begin
                sclk_d = 1'b0;
                if (!tick) begin
                    tmr_d = tmr_q - 4'd1;
                end else begin
                    latch_d      = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tmr_q         <= 4'd0;
            bit_cnt_q     <= 4'd0;
            row_q         <= '0;
            col_q         <= '0;
            sclk_q        <= 1'b0;
            sdo_q         <= 1'b0;
            latch_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            snap_col_q    <= 3'd0;
            snap_player_q <= 2'd0;
            blank_q       <= 1'b0;
            lsb_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            bit_cnt_q     <= bit_cnt_d;
            row_q         <= row_d;
            col_q         <= col_d;
            sclk_q        <= sclk_d;
            sdo_q         <= sdo_d;
            latch_q       <= latch_d;
            frame_done_q  <= frame_done_d;
            snap_col_q    <= snap_col_d;
            snap_player_q <= snap_player_d;
            blank_q       <= blank_d;
            lsb_q         <= lsb_d;
        end
    end

    assign row_read   = row_q;
    assign col_read   = col_q;
    assign sclk       = sclk_q;
    assign sdo        = sdo_q;
    assign latch      = latch_q;
    assign frame_done = frame_done_q;

endmodule
